// File: rtl/xor_pkg.sv
// rtl/xor_pkg.sv - shared state encoding and default sizing for the XOR checksum block
package xor_pkg;

    // Two-state frame engine: collecting beats, or presenting a result.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } xor_state_e;

    localparam int XOR_DEFAULT_WIDTH     = 8;
    localparam int XOR_DEFAULT_MAX_BEATS = 16;

endpackage : xor_pkg

// File: rtl/xor_checksum_parity_reduce.sv
// rtl/xor_checksum_parity_reduce.sv - combinational XOR-reduction of one data word
module parity_reduce #(
    parameter int WIDTH = xor_pkg::XOR_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    // Odd number of set bits gives parity 1.
    assign parity_o = ^data_i;

endmodule : parity_reduce

// File: rtl/xor_checksum.sv
// rtl/xor_checksum.sv - frames input beats and reports their XOR, beat count and truncation flag
module xor_checksum
    import xor_pkg::*;
#(
    parameter int WIDTH     = XOR_DEFAULT_WIDTH,
    parameter int MAX_BEATS = XOR_DEFAULT_MAX_BEATS,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_beats,
    output logic             out_err,
    output logic             out_parity
);

    xor_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [CW-1:0]    res_beats_q, res_beats_d;
    logic             res_err_q, res_err_d;

    logic             accept;
    logic [CW-1:0]    cnt_inc;
    logic             at_max;

    // Reset forces the handshake view to "ready, nothing to offer" regardless of state.
    assign in_ready  = rst | (state_q == ACCUM);
    assign out_valid = ~rst & (state_q == HOLD);

    assign accept  = in_valid & (state_q == ACCUM);
    assign cnt_inc = cnt_q + CW'(1);
    assign at_max  = (cnt_inc == CW'(MAX_BEATS));

    // Register update; reset discards any partial frame and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_beats_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_beats_q <= res_beats_d;
            res_err_q   <= res_err_d;
        end
    end

    // Next-state: fold beats while accumulating, latch result on frame close, clear on result handoff.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_beats_d = res_beats_q;
        res_err_d   = res_err_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q ^ in_data;
                    cnt_d = cnt_inc;
                    if (in_last || at_max) begin
                        res_data_d  = acc_q ^ in_data;
                        res_beats_d = cnt_inc;
                        // Closing without in_last can only mean the beat limit was hit.
                        res_err_d   = ~in_last;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign out_data  = res_data_q;
    assign out_beats = res_beats_q;
    assign out_err   = res_err_q;

    parity_reduce #(
        .WIDTH(WIDTH)
    ) u_parity (
        .data_i  (res_data_q),
        .parity_o(out_parity)
    );

endmodule : xor_checksum

// File: doc/xor_checksum.md
XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data beat width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter MAX_BEATS, default 16, giving the maximum beats per frame (legal range 1..256).
REQ-003 Port clk SHALL be input, 1 bit: the single clock; every register SHALL update on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be input, 1 bit: an input beat is present.
REQ-006 Port in_data SHALL be input, WIDTH bits: the input beat.
REQ-007 Port in_last SHALL be input, 1 bit: the current beat ends the frame.
REQ-008 Port in_ready SHALL be output, 1 bit: the block accepts a beat this cycle.
REQ-009 Port out_valid SHALL be output, 1 bit: the checksum result is presented.
REQ-010 Port out_ready SHALL be input, 1 bit: the consumer takes the result.
REQ-011 Port out_data SHALL be output, WIDTH bits: the bitwise XOR of all beats in the frame.
REQ-012 Port out_beats SHALL be output, $clog2(MAX_BEATS+1) bits: the number of beats in the frame.
REQ-013 Port out_err SHALL be output, 1 bit: the frame was truncated at MAX_BEATS without in_last.
REQ-014 Port out_parity SHALL be output, 1 bit: the XOR-reduction of out_data.

Function
REQ-015 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1; cycles with in_valid=0 SHALL leave the accumulator and the beat count unchanged.
REQ-016 The block SHALL have exactly two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 In ACCUM, each accepted beat SHALL update acc <= acc ^ in_data and cnt <= cnt+1.
REQ-018 In ACCUM, an accepted beat with in_last=1, or with cnt+1==MAX_BEATS, SHALL load out_data <= acc^in_data and out_beats <= cnt+1, and SHALL move the block to HOLD.
REQ-019 out_err SHALL load 1 only when the frame closes because cnt+1==MAX_BEATS and in_last=0; otherwise it SHALL load 0.
REQ-020 The result SHALL appear with out_valid=1 in the cycle after the closing beat is accepted (latency 1).
REQ-021 In HOLD, out_data, out_beats, out_err and out_parity SHALL stay stable until out_ready=1.
REQ-022 In HOLD with out_ready=1, the next state SHALL be ACCUM with acc=0 and cnt=0; there is no same-cycle bypass, so at least one cycle passes between a result handshake and the next accepted beat.
REQ-023 After a truncated frame, the following beats SHALL form a new frame, counted from 1.
REQ-024 out_parity SHALL be combinational from the out_data register only.
REQ-025 When MAX_BEATS=1, every beat SHALL close its own frame, with out_err = ~in_last.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL go to ACCUM with acc=0, cnt=0, out_data=0, out_beats=0 and out_err=0, from either state; a partial frame SHALL be discarded.
REQ-027 While in reset, in_ready SHALL read 1 and out_valid SHALL read 0; rst SHALL take priority over any simultaneous handshake.

Structure
REQ-028 Package xor_pkg SHALL hold the state enum (ACCUM, HOLD) and the default constants for WIDTH and MAX_BEATS.
REQ-029 Sub-module parity_reduce, parametrised by WIDTH and purely combinational, SHALL produce out_parity; all other logic SHALL sit in one module.

Verification (WIDTH=8, MAX_BEATS=4)
REQ-030 Single beat 0xA5 with in_last=1 -> next cycle out_valid=1, out_data=0xA5, out_beats=1, out_err=0, out_parity=0.
REQ-031 Beats 0x0F, 0xF0, 0xFF (last), with one in_valid=0 gap cycle inserted -> out_data=0x00, out_beats=3, out_parity=0.
REQ-032 Result 0x3C held with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> ACCUM next cycle.
REQ-033 Beats 0x01, 0x02, 0x04, 0x08, 0x10 (last only on 0x10) -> first result 0x0F, out_beats=4, out_err=1; second result 0x10, out_beats=1, out_err=0.
REQ-034 Beats 0x11, 0x22, then rst=1 for one cycle, then 0x3C (last) -> all outputs 0 after reset; result 0x3C, out_beats=1.
REQ-035 rst=1 in the same cycle as a HOLD handshake -> ACCUM with all outputs 0, and no beat lost after release.
